adder_bist: RTL
===============

Name: adder_bist

Overview:
- Hardware exhaustive self-test engine for the 6-bit adder: the on-chip counterpart of the software vector bench.
- Drives every operand pair (x, y) in 0..63 x 0..63 onto the adder under test, waits a settle time, then samples the 7-bit sum and compares it to an internally computed x+y.
- Counts mismatches and captures the first failing vector index.
- Sits beside the adder; start/abort come from a test controller, and results are read back after done.

Parameters:
- WIDTH, 6, operand width; the vector count is 2^(2*WIDTH) = 4096.
- SETTLE, 1, number of cycles each vector is held before its CHECK cycle; legal range is 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- abort  in  1  synchronous; terminates a run in progress
- s_i  in  WIDTH+1  sum returned by the adder under test
- x_o  out  WIDTH  operand x driven to the adder
- y_o  out  WIDTH  operand y driven to the adder
- busy  out  1  high while in APPLY or CHECK
- done  out  1  high while in DONE
- pass  out  1  done && err_count==0
- err_count  out  2*WIDTH+1  number of mismatching vectors (0..4096)
- first_err_idx  out  2*WIDTH  index of the first mismatching vector
- first_err_valid  out  1  first_err_idx holds a captured index

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0: x_o, y_o, busy, done, pass, err_count, first_err_idx, first_err_valid, and the internal idx and wait counter. Reset mid-run discards all results.
- Vector mapping: idx is 2*WIDTH bits. x_o=idx[2W-1:W], y_o=idx[W-1:0]. Ordering is x-major, y-minor: idx 0 is (0,0), idx 1 is (0,1), idx 64 is (1,0).
- Expected sum: {1'b0,x}+{1'b0,y}, full WIDTH+1 bits. The compare covers all WIDTH+1 bits, carry included.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE -> APPLY on start: clear idx, err_count, first_err_*; drive x_o/y_o for idx 0; wait counter=0.
- APPLY: the wait counter increments each cycle. When the counter reaches SETTLE-1, go to CHECK. Each vector spends SETTLE cycles in APPLY.
- CHECK (1 cycle): sample s_i. On a mismatch, err_count+=1; if first_err_valid=0, set first_err_idx=idx and first_err_valid=1.
  - If idx==4095, go to DONE.
  - Otherwise idx+=1, x_o/y_o update to the new idx on the same edge, go to APPLY.
- Each vector takes SETTLE+1 cycles. With start sampled at edge 0, done rises at edge 4096*(SETTLE+1).
- DONE: done=1, busy=0, pass valid. Results and x_o/y_o (last vector, 63/63) hold until the next start or reset.
- start while busy is ignored.
- abort while busy: go to IDLE next edge. busy=0, done stays 0. err_count/first_err_* keep their partial values and x_o/y_o hold.
- abort in IDLE or DONE has no effect.
- start and abort in the same cycle:
  - In IDLE/DONE, start wins and a new run begins.
  - While busy, abort wins.
- err_count never wraps; the maximum is 4096, which fits in 2W+1 bits.
- pass is registered and equals done && (err_count==0). It is never 1 outside DONE.

Test Plan:
- Ideal adder model, SETTLE=1, start pulse -> busy the cycle after start; done rises at edge 8192; pass=1, err_count=0, first_err_valid=0, x_o=y_o=63.
- Fault model s_i[0] stuck-at-0 -> err_count=2048 (all odd sums); first_err_idx=1 (x=0,y=1); pass=0.
- Fault model s_i[6] forced 0 (carry dropped) -> err_count=2016 (pairs with x+y>=64); first_err_idx=127 (x=1,y=63).
- SETTLE=3 with an adder model whose output updates 2 cycles after its inputs -> pass=1 and done at edge 16384. The same model with SETTLE=1 -> errors on most vectors and pass=0.
- Abort at idx 100 with the stuck-at-0 model -> IDLE and done=0; err_count=50, first_err_idx=1 held. A start pulse driven mid-run is ignored; a subsequent start clears the counts and a full run completes.
- rst_n pulsed low mid-APPLY (asynchronous, not clock aligned) -> all outputs are 0 immediately. start after release -> a normal full run with correct results.

Source files
------------

// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self-test engine for a WIDTH-bit adder.
//
// It walks every operand pair (x, y) in x-major, y-minor order. Each vector is held for
// SETTLE cycles in APPLY. The returned sum is then sampled in a single CHECK cycle and
// compared with the full-width reference {1'b0,x} + {1'b0,y}. The engine counts
// mismatches and captures the index of the first failing vector.
//
// Parameters:
//   WIDTH  - operand width; 2^(2*WIDTH) vectors per run
//   SETTLE - cycles each vector is held before its CHECK cycle (legal range 1..15)
//
// Ports:
//   clk             - rising-edge clock
//   rst_n           - asynchronous active-low reset
//   start           - one-cycle pulse, begins a run from IDLE or DONE
//   abort           - synchronous, terminates a run in progress
//   s_i             - sum returned by the adder under test (WIDTH+1 bits)
//   x_o, y_o        - operands driven to the adder
//   busy            - high in APPLY or CHECK
//   done            - high in DONE
//   pass            - done && err_count == 0 (registered)
//   err_count       - number of mismatching vectors, saturates naturally at 2^(2*WIDTH)
//   first_err_idx   - index of the first mismatching vector
//   first_err_valid - first_err_idx holds a captured index
module adder_bist #(
   parameter int unsigned WIDTH  = 6,
   parameter int unsigned SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [WIDTH:0]     s_i,
   output logic [WIDTH-1:0]   x_o,
   output logic [WIDTH-1:0]   y_o,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [2*WIDTH-1:0] first_err_idx,
   output logic               first_err_valid
);

   localparam int unsigned IdxW = 2 * WIDTH;
   localparam int unsigned CntW = 2 * WIDTH + 1;
   localparam logic [IdxW-1:0] LastIdx    = '1;
   localparam logic [3:0]      SettleLast = 4'(SETTLE - 1);

   typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

   state_e state_q, state_d;

   logic [IdxW-1:0] idx_q, idx_d;
   logic [3:0]      wait_q, wait_d;
   logic [CntW-1:0] err_count_q, err_count_d;
   logic [IdxW-1:0] first_err_idx_q, first_err_idx_d;
   logic            first_err_valid_q, first_err_valid_d;
   logic            pass_q, pass_d;

   logic [WIDTH:0]  exp_sum;
   logic            mismatch;
   logic            run_start;
   logic            check_en;

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // FSM: next-state logic. abort has priority over everything while busy; start only
   // matters in IDLE/DONE, where it also beats a simultaneous abort.
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StApply;
            end
         end
         StApply: begin
            if (abort) begin
               state_d = StIdle;
            end else if (wait_q == SettleLast) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (abort) begin
               state_d = StIdle;
            end else if (idx_q == LastIdx) begin
               state_d = StDone;
            end else begin
               state_d = StApply;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------------
   always_comb begin
      busy            = (state_q == StApply) || (state_q == StCheck);
      done            = (state_q == StDone);
      pass            = pass_q;
      x_o             = idx_q[IdxW-1:WIDTH];
      y_o             = idx_q[WIDTH-1:0];
      err_count       = err_count_q;
      first_err_idx   = first_err_idx_q;
      first_err_valid = first_err_valid_q;
   end

   // ---------------------------------------------------------------------------------------
   // Datapath: vector index, settle counter, error bookkeeping
   // ---------------------------------------------------------------------------------------
   // Reference includes the carry bit so a dropped carry is detected.
   assign exp_sum   = {1'b0, x_o} + {1'b0, y_o};
   assign mismatch  = (s_i != exp_sum);
   assign run_start = ((state_q == StIdle) || (state_q == StDone)) && start;
   assign check_en  = (state_q == StCheck) && !abort;

   always_comb begin
      idx_d             = idx_q;
      wait_d            = wait_q;
      err_count_d       = err_count_q;
      first_err_idx_d   = first_err_idx_q;
      first_err_valid_d = first_err_valid_q;

      if (run_start) begin
         idx_d             = '0;
         wait_d            = '0;
         err_count_d       = '0;
         first_err_idx_d   = '0;
         first_err_valid_d = 1'b0;
      end else if ((state_q == StApply) && !abort) begin
         wait_d = (wait_q == SettleLast) ? 4'd0 : wait_q + 4'd1;
      end else if (check_en) begin
         // At most 2^(2*WIDTH) increments per run, so the extra counter bit never wraps.
         if (mismatch) begin
            err_count_d = err_count_q + CntW'(1);
            if (!first_err_valid_q) begin
               first_err_idx_d   = idx_q;
               first_err_valid_d = 1'b1;
            end
         end
         // The last vector stays on x_o/y_o through DONE.
         if (idx_q != LastIdx) begin
            idx_d  = idx_q + IdxW'(1);
            wait_d = '0;
         end
      end

      pass_d = (state_d == StDone) && (err_count_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q             <= '0;
         wait_q            <= '0;
         err_count_q       <= '0;
         first_err_idx_q   <= '0;
         first_err_valid_q <= 1'b0;
         pass_q            <= 1'b0;
      end else begin
         idx_q             <= idx_d;
         wait_q            <= wait_d;
         err_count_q       <= err_count_d;
         first_err_idx_q   <= first_err_idx_d;
         first_err_valid_q <= first_err_valid_d;
         pass_q            <= pass_d;
      end
   end

endmodule
